// File: rtl/decode_issue_pipe_pkg.sv
// Shared types and default widths for the decode-to-writeback pipe.
// Field order of ctl_t matches the packed id_ctl bundle from decode.
package decode_issue_pipe_pkg;

  localparam int DEF_XLEN      = 32;
  localparam int DEF_RA_W      = 5;
  localparam int DEF_FUNC_W    = 10;
  localparam int DEF_LD_W      = 3;
  localparam int DEF_MEM_DEPTH = 2;
  localparam int DEF_WB_DEPTH  = 3;
  localparam int DEF_CNT_W     = 16;

  localparam int X0 = 0;

  typedef struct packed {
    logic reg_wr;
    logic jmp;
    logic uncond_jmp;
    logic rel_reg_jmp;
    logic mem_wr;
    logic dmem_bus_use;
    logic uses_a1;
  } ctl_t;

endpackage

// File: rtl/decode_issue_pipe_if.sv
// Decode-side inputs and ex/mem/wb outputs of decode_issue_pipe.
// master: decode + downstream stages, slave: the pipe itself.
interface decode_issue_pipe_if
  import decode_issue_pipe_pkg::*;
#(
  parameter int XLEN   = DEF_XLEN,
  parameter int RA_W   = DEF_RA_W,
  parameter int FUNC_W = DEF_FUNC_W,
  parameter int LD_W   = DEF_LD_W,
  parameter int CNT_W  = DEF_CNT_W
);

  logic              id_valid;
  logic [RA_W-1:0]   id_a0;
  logic [RA_W-1:0]   id_a1;
  logic [RA_W-1:0]   id_a2;
  logic [XLEN-1:0]   id_d0;
  logic [XLEN-1:0]   id_d1;
  logic [XLEN-1:0]   id_imm;
  logic              id_en_imm;
  logic [FUNC_W-1:0] id_func;
  ctl_t              id_ctl;
  logic [LD_W-1:0]   id_ld_code;
  logic              ext_stall;
  logic              squash;

  logic              hz_stall;
  logic              ex_valid;
  logic [XLEN-1:0]   ex_data1;
  logic [XLEN-1:0]   ex_data2;
  logic [FUNC_W-1:0] ex_func;
  logic              ex_en_jmp;
  logic              ex_en_uncond_jmp;
  logic              ex_en_rel_reg_jmp;
  logic [XLEN-1:0]   ex_imm;
  logic              mem_en_wr;
  logic              mem_bus_use;
  logic [XLEN-1:0]   mem_data;
  logic              wb_en_reg_wr;
  logic [RA_W-1:0]   wb_a2;
  logic [LD_W-1:0]   wb_ld_code;
  logic [XLEN-1:0]   wb_imm;
  logic [CNT_W-1:0]  hz_cnt;

  modport master (
    output id_valid, id_a0, id_a1, id_a2,
    output id_d0, id_d1, id_imm, id_en_imm,
    output id_func, id_ctl, id_ld_code,
    output ext_stall, squash,
    input  hz_stall, ex_valid,
    input  ex_data1, ex_data2, ex_func,
    input  ex_en_jmp, ex_en_uncond_jmp,
    input  ex_en_rel_reg_jmp, ex_imm,
    input  mem_en_wr, mem_bus_use, mem_data,
    input  wb_en_reg_wr, wb_a2,
    input  wb_ld_code, wb_imm, hz_cnt
  );

  modport slave (
    input  id_valid, id_a0, id_a1, id_a2,
    input  id_d0, id_d1, id_imm, id_en_imm,
    input  id_func, id_ctl, id_ld_code,
    input  ext_stall, squash,
    output hz_stall, ex_valid,
    output ex_data1, ex_data2, ex_func,
    output ex_en_jmp, ex_en_uncond_jmp,
    output ex_en_rel_reg_jmp, ex_imm,
    output mem_en_wr, mem_bus_use, mem_data,
    output wb_en_reg_wr, wb_a2,
    output wb_ld_code, wb_imm, hz_cnt
  );

endinterface

// File: rtl/decode_issue_pipe_delay.sv
// Register chain with hold and bubble-load; exposes every stage.
// Ports: clk, rst (async low), hold, bubble, d, taps[1..DEPTH].
module decode_issue_pipe_delay #(
  parameter int W     = 1,
  parameter int DEPTH = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    hold,
  input  logic                    bubble,
  input  logic [W-1:0]            d,
  output logic [DEPTH:1][W-1:0]   taps
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      taps <= '0;
    end else if (!hold) begin
      taps[1] <= bubble ? '0 : d;
      for (int k = 2; k <= DEPTH; k++) begin
        taps[k] <= taps[k-1];
      end
    end
  end

endmodule

// File: rtl/decode_issue_pipe.sv
// Decode-to-writeback control pipe with RAW scoreboard and stall count.
// Ports: clk, rst (async low), bus (decode_issue_pipe_if.slave).
module decode_issue_pipe
  import decode_issue_pipe_pkg::*;
#(
  parameter int XLEN      = DEF_XLEN,
  parameter int RA_W      = DEF_RA_W,
  parameter int FUNC_W    = DEF_FUNC_W,
  parameter int LD_W      = DEF_LD_W,
  parameter int MEM_DEPTH = DEF_MEM_DEPTH,
  parameter int WB_DEPTH  = DEF_WB_DEPTH,
  parameter int CNT_W     = DEF_CNT_W
) (
  input logic                clk,
  input logic                rst,
  decode_issue_pipe_if.slave bus
);

  localparam int WW = RA_W + 1;
  localparam int LW = LD_W + XLEN;
  localparam int MW = XLEN + 2;

  logic hold;
  logic hz;
  logic bubble;
  logic m0;
  logic m1;

  logic [WB_DEPTH:1][0:0]     v_t;
  logic [WB_DEPTH:1][WW-1:0]  w_t;
  logic [WB_DEPTH:1][LW-1:0]  l_t;
  logic [MEM_DEPTH:1][MW-1:0] m_t;

  logic v1;
  logic vm;
  logic vw;

  logic [XLEN-1:0]   d1_q;
  logic [XLEN-1:0]   d2_q;
  logic [FUNC_W-1:0] func_q;
  logic              jmp_q;
  logic              uj_q;
  logic              rrj_q;
  logic [CNT_W-1:0]  cnt_q;

  logic unused_taps;

  assign hold   = bus.ext_stall;
  // squash and a hazard both load an all-zero stage 1
  assign bubble = hz | bus.squash;

  decode_issue_pipe_delay #(.W(1), .DEPTH(WB_DEPTH)) u_valid (
    .clk    (clk),
    .rst    (rst),
    .hold   (hold),
    .bubble (bubble),
    .d      (bus.id_valid),
    .taps   (v_t)
  );

  decode_issue_pipe_delay #(.W(WW), .DEPTH(WB_DEPTH)) u_wr (
    .clk    (clk),
    .rst    (rst),
    .hold   (hold),
    .bubble (bubble),
    .d      ({bus.id_ctl.reg_wr, bus.id_a2}),
    .taps   (w_t)
  );

  decode_issue_pipe_delay #(.W(LW), .DEPTH(WB_DEPTH)) u_ld (
    .clk    (clk),
    .rst    (rst),
    .hold   (hold),
    .bubble (bubble),
    .d      ({bus.id_ld_code, bus.id_imm}),
    .taps   (l_t)
  );

  decode_issue_pipe_delay #(.W(MW), .DEPTH(MEM_DEPTH)) u_mem (
    .clk    (clk),
    .rst    (rst),
    .hold   (hold),
    .bubble (bubble),
    .d      ({bus.id_ctl.mem_wr,
              bus.id_ctl.dmem_bus_use,
              bus.id_d1}),
    .taps   (m_t)
  );

  assign unused_taps = ^{l_t, m_t};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      d1_q   <= '0;
      d2_q   <= '0;
      func_q <= '0;
      jmp_q  <= 1'b0;
      uj_q   <= 1'b0;
      rrj_q  <= 1'b0;
    end else if (!hold) begin
      if (bubble) begin
        d1_q   <= '0;
        d2_q   <= '0;
        func_q <= '0;
        jmp_q  <= 1'b0;
        uj_q   <= 1'b0;
        rrj_q  <= 1'b0;
      end else begin
        d1_q   <= bus.id_d0;
        d2_q   <= bus.id_en_imm ? bus.id_imm
                                : bus.id_d1;
        func_q <= bus.id_func;
        jmp_q  <= bus.id_ctl.jmp;
        uj_q   <= bus.id_ctl.uncond_jmp;
        rrj_q  <= bus.id_ctl.rel_reg_jmp;
      end
    end
  end

  // the last stage still counts: regfile commits on the same edge
  always_comb begin
    m0 = 1'b0;
    m1 = 1'b0;
    for (int k = 1; k <= WB_DEPTH; k++) begin
      if (v_t[k][0] && w_t[k][RA_W]) begin
        if (w_t[k][RA_W-1:0] == bus.id_a0) m0 = 1'b1;
        if (w_t[k][RA_W-1:0] == bus.id_a1) m1 = 1'b1;
      end
    end
  end

  assign hz = bus.id_valid &
              ((m0 & (bus.id_a0 != RA_W'(X0))) |
               (bus.id_ctl.uses_a1 & m1 &
                (bus.id_a1 != RA_W'(X0))));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else if (!hold && hz && cnt_q != '1) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign v1 = v_t[1][0];
  assign vm = v_t[MEM_DEPTH][0];
  assign vw = v_t[WB_DEPTH][0];

  assign bus.hz_stall = hz & ~hold;
  assign bus.hz_cnt   = cnt_q;

  assign bus.ex_valid          = v1;
  assign bus.ex_data1          = v1 ? d1_q : '0;
  assign bus.ex_data2          = v1 ? d2_q : '0;
  assign bus.ex_func           = v1 ? func_q : '0;
  assign bus.ex_en_jmp         = v1 & jmp_q;
  assign bus.ex_en_uncond_jmp  = v1 & uj_q;
  assign bus.ex_en_rel_reg_jmp = v1 & rrj_q;
  assign bus.ex_imm            = v1 ? l_t[1][XLEN-1:0] : '0;

  assign bus.mem_en_wr   = vm & m_t[MEM_DEPTH][XLEN+1];
  assign bus.mem_bus_use = vm & m_t[MEM_DEPTH][XLEN];
  assign bus.mem_data    = vm ? m_t[MEM_DEPTH][XLEN-1:0] : '0;

  assign bus.wb_en_reg_wr = vw & w_t[WB_DEPTH][RA_W];
  assign bus.wb_a2        = vw ? w_t[WB_DEPTH][RA_W-1:0] : '0;
  assign bus.wb_ld_code   = vw ? l_t[WB_DEPTH][LW-1:XLEN] : '0;
  assign bus.wb_imm       = vw ? l_t[WB_DEPTH][XLEN-1:0] : '0;

endmodule

// File: tb/tb_decode_issue_pipe.sv
// Bench for decode_issue_pipe: directed steps, then random traffic
// against a stage-array reference model; second DUT with CNT_W=2.
module tb_decode_issue_pipe;
  import decode_issue_pipe_pkg::*;

  localparam int MEMD = 2;
  localparam int WBD  = 3;

  typedef struct {
    logic        valid;
    logic [4:0]  a0, a1, a2;
    logic [31:0] d0, d1, imm;
    logic        en_imm;
    logic [9:0]  func;
    ctl_t        ctl;
    logic [2:0]  ld;
    logic        ext, squash;
  } stim_t;

  typedef struct {
    logic        valid;
    logic [31:0] d1, d2, imm, sd;
    logic [9:0]  func;
    logic        jmp, uj, rrj, mw, bu, rw;
    logic [4:0]  a2;
    logic [2:0]  ld;
  } stage_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   errors = 0;
  int   checks = 0;

  stage_t      st [1:WBD];
  logic [15:0] cnt;
  logic [1:0]  cnt2;
  stim_t       cur;
  stim_t       s;

  decode_issue_pipe_if mb ();
  decode_issue_pipe_if #(.CNT_W(2)) sb ();

  decode_issue_pipe u_dut (.clk(clk), .rst(rst), .bus(mb));
  decode_issue_pipe #(.CNT_W(2)) u_sat (
    .clk(clk), .rst(rst), .bus(sb));

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic stim_t nop();
    stim_t n = '{default: '0};
    return n;
  endfunction

  function automatic stim_t rnd();
    stim_t n;
    n.valid  = $urandom_range(3) != 0;
    n.a0     = 5'($urandom_range(7));
    n.a1     = 5'($urandom_range(7));
    n.a2     = 5'($urandom_range(7));
    n.d0     = $urandom;
    n.d1     = $urandom;
    n.imm    = $urandom;
    n.en_imm = 1'($urandom);
    n.func   = 10'($urandom);
    n.ctl    = ctl_t'($urandom);
    n.ld     = 3'($urandom);
    n.ext    = $urandom_range(9) == 0;
    n.squash = $urandom_range(9) == 0;
    return n;
  endfunction

  task automatic apply(input stim_t n);
    cur = n;
    mb.id_valid = n.valid;  sb.id_valid = n.valid;
    mb.id_a0 = n.a0;        sb.id_a0 = n.a0;
    mb.id_a1 = n.a1;        sb.id_a1 = n.a1;
    mb.id_a2 = n.a2;        sb.id_a2 = n.a2;
    mb.id_d0 = n.d0;        sb.id_d0 = n.d0;
    mb.id_d1 = n.d1;        sb.id_d1 = n.d1;
    mb.id_imm = n.imm;      sb.id_imm = n.imm;
    mb.id_en_imm = n.en_imm; sb.id_en_imm = n.en_imm;
    mb.id_func = n.func;    sb.id_func = n.func;
    mb.id_ctl = n.ctl;      sb.id_ctl = n.ctl;
    mb.id_ld_code = n.ld;   sb.id_ld_code = n.ld;
    mb.ext_stall = n.ext;   sb.ext_stall = n.ext;
    mb.squash = n.squash;   sb.squash = n.squash;
  endtask

  task automatic model_reset();
    for (int k = 1; k <= WBD; k++) st[k] = '{default: '0};
    cnt  = '0;
    cnt2 = '0;
  endtask

  // an instruction may issue only if no in-flight writer targets its sources
  function automatic logic model_hz(input stim_t n);
    logic r0 = 1'b0;
    logic r1 = 1'b0;
    for (int k = 1; k <= WBD; k++) begin
      if (st[k].valid && st[k].rw) begin
        if (n.a0 != 0 && st[k].a2 == n.a0) r0 = 1'b1;
        if (n.a1 != 0 && st[k].a2 == n.a1) r1 = 1'b1;
      end
    end
    return n.valid && (r0 || (n.ctl.uses_a1 && r1));
  endfunction

  task automatic model_edge(input stim_t n);
    logic h;
    if (n.ext) return;
    h = model_hz(n);
    for (int k = WBD; k > 1; k--) st[k] = st[k-1];
    if (h || n.squash) begin
      st[1] = '{default: '0};
    end else begin
      st[1].valid = n.valid;
      st[1].d1    = n.d0;
      st[1].d2    = n.en_imm ? n.imm : n.d1;
      st[1].imm   = n.imm;
      st[1].sd    = n.d1;
      st[1].func  = n.func;
      st[1].jmp   = n.ctl.jmp;
      st[1].uj    = n.ctl.uncond_jmp;
      st[1].rrj   = n.ctl.rel_reg_jmp;
      st[1].mw    = n.ctl.mem_wr;
      st[1].bu    = n.ctl.dmem_bus_use;
      st[1].rw    = n.ctl.reg_wr;
      st[1].a2    = n.a2;
      st[1].ld    = n.ld;
    end
    if (h) begin
      if (cnt != 16'hFFFF) cnt = cnt + 1;
      if (cnt2 != 2'd3) cnt2 = cnt2 + 1;
    end
  endtask

  task automatic check_all(input stim_t n);
    stage_t e, m, w;
    e = st[1];
    m = st[MEMD];
    w = st[WBD];
    chk("hz_stall", mb.hz_stall, model_hz(n) & ~n.ext);
    chk("ex_valid", mb.ex_valid, e.valid);
    chk("ex_data1", mb.ex_data1, e.valid ? e.d1 : 0);
    chk("ex_data2", mb.ex_data2, e.valid ? e.d2 : 0);
    chk("ex_func", mb.ex_func, e.valid ? e.func : 0);
    chk("ex_jmp", mb.ex_en_jmp, e.valid & e.jmp);
    chk("ex_uj", mb.ex_en_uncond_jmp, e.valid & e.uj);
    chk("ex_rrj", mb.ex_en_rel_reg_jmp, e.valid & e.rrj);
    chk("ex_imm", mb.ex_imm, e.valid ? e.imm : 0);
    chk("mem_wr", mb.mem_en_wr, m.valid & m.mw);
    chk("mem_bus", mb.mem_bus_use, m.valid & m.bu);
    chk("mem_data", mb.mem_data, m.valid ? m.sd : 0);
    chk("wb_wr", mb.wb_en_reg_wr, w.valid & w.rw);
    chk("wb_a2", mb.wb_a2, w.valid ? w.a2 : 0);
    chk("wb_ld", mb.wb_ld_code, w.valid ? w.ld : 0);
    chk("wb_imm", mb.wb_imm, w.valid ? w.imm : 0);
    chk("hz_cnt", mb.hz_cnt, cnt);
    chk("sat_cnt", sb.hz_cnt, cnt2);
  endtask

  task automatic tick(input stim_t n);
    @(negedge clk);
    apply(n);
    #1;
    check_all(n);
    @(posedge clk);
    model_edge(n);
    #2;
  endtask

  task automatic do_reset();
    @(negedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    #1;
    check_all(cur);
    @(posedge clk);
    #2;
    check_all(cur);
    rst = 1'b1;
  endtask

  initial begin
    apply(nop());
    model_reset();
    #2;
    check_all(cur);
    @(posedge clk);
    #2;
    rst = 1'b1;

    // first issue after reset: ADDI x5, imm 0x10
    s = nop(); s.valid = 1; s.a2 = 5; s.imm = 32'h10;
    s.en_imm = 1; s.ctl.reg_wr = 1;
    tick(s);
    chk("addi_ex_d2", mb.ex_data2, 32'h10);
    tick(nop());
    chk("addi_wb_early", mb.wb_en_reg_wr, 0);
    tick(nop());
    chk("addi_wb_wr", mb.wb_en_reg_wr, 1);
    chk("addi_wb_a2", mb.wb_a2, 5);

    s = nop(); s.valid = 1; s.d1 = 32'hDEADBEEF;
    s.ctl.mem_wr = 1; s.ctl.dmem_bus_use = 1;
    s.ctl.uses_a1 = 1;
    tick(s);
    tick(nop());
    chk("st_mem_data", mb.mem_data, 32'hDEADBEEF);
    chk("st_mem_wr", mb.mem_en_wr, 1);

    // reset with every stage valid
    for (int i = 1; i <= 3; i++) begin
      s = nop(); s.valid = 1; s.a2 = 5'(i);
      s.ctl.reg_wr = 1; s.imm = 32'(i);
      tick(s);
    end
    chk("full_wb_wr", mb.wb_en_reg_wr, 1);
    do_reset();
    chk("rst_wb_wr", mb.wb_en_reg_wr, 0);
    chk("rst_ex_valid", mb.ex_valid, 0);

    // RAW on x7
    s = nop(); s.valid = 1; s.a2 = 7; s.ctl.reg_wr = 1;
    s.d0 = 32'h11;
    tick(s);
    s = nop(); s.valid = 1; s.a0 = 7; s.a2 = 8;
    s.d0 = 32'h22;
    tick(s);
    chk("raw1_stall", mb.hz_stall, 1);
    chk("raw1_bubble", mb.ex_valid, 0);
    tick(s);
    chk("raw2_stall", mb.hz_stall, 1);
    tick(s);
    chk("raw3_stall", mb.hz_stall, 0);
    chk("raw3_bubble", mb.ex_valid, 0);
    chk("raw_cnt", mb.hz_cnt, 3);
    tick(s);
    chk("raw_issue", mb.ex_valid, 1);
    chk("raw_issue_d1", mb.ex_data1, 32'h22);

    // writes to x0 never block readers of x0
    s = nop(); s.valid = 1; s.a2 = 0; s.ctl.reg_wr = 1;
    tick(s);
    s = nop(); s.valid = 1; s.a0 = 0; s.a1 = 0;
    s.ctl.uses_a1 = 1; s.d0 = 32'h33;
    tick(s);
    chk("x0_stall", mb.hz_stall, 0);
    chk("x0_issue", mb.ex_valid, 1);
    chk("x0_cnt", mb.hz_cnt, 3);

    // squashed jump behind an older writer
    s = nop(); s.valid = 1; s.a2 = 3; s.ctl.reg_wr = 1;
    tick(s);
    s = nop(); s.valid = 1; s.ctl.jmp = 1;
    s.ctl.uncond_jmp = 1; s.squash = 1;
    tick(s);
    chk("sq_valid", mb.ex_valid, 0);
    chk("sq_jmp", mb.ex_en_jmp, 0);
    tick(nop());
    chk("sq_old_wb", mb.wb_en_reg_wr, 1);
    chk("sq_old_a2", mb.wb_a2, 3);

    // freeze with a hazard pending; squash must be ignored
    do_reset();
    s = nop(); s.valid = 1; s.a2 = 9; s.ctl.reg_wr = 1;
    s.d0 = 32'h99;
    tick(s);
    s = nop(); s.valid = 1; s.a1 = 9; s.ctl.uses_a1 = 1;
    s.ext = 1; s.squash = 1;
    for (int i = 0; i < 4; i++) begin
      tick(s);
      chk("stall_hz", mb.hz_stall, 0);
      chk("stall_valid", mb.ex_valid, 1);
      chk("stall_d1", mb.ex_data1, 32'h99);
      chk("stall_cnt", mb.hz_cnt, 0);
    end
    s.ext = 0; s.squash = 0;
    for (int i = 0; i < 3; i++) tick(s);
    chk("post_stall_cnt", mb.hz_cnt, 3);

    // five hazard cycles against a 2-bit counter
    do_reset();
    s = nop(); s.valid = 1; s.a2 = 12; s.ctl.reg_wr = 1;
    tick(s);
    s = nop(); s.valid = 1; s.a0 = 12;
    for (int i = 0; i < 3; i++) tick(s);
    s = nop(); s.valid = 1; s.a2 = 13; s.ctl.reg_wr = 1;
    tick(s);
    s = nop(); s.valid = 1; s.a1 = 13; s.ctl.uses_a1 = 1;
    for (int i = 0; i < 2; i++) tick(s);
    chk("sat_wide", mb.hz_cnt, 5);
    chk("sat_narrow", sb.hz_cnt, 3);

    for (int i = 0; i < 300; i++) begin
      if (i == 150) do_reset();
      tick(rnd());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
